// File: rtl/fetch_queue_pkg.sv
// Shared pipeline definitions for fetch, decode and hazard logic.
package fetch_queue_pkg;

  localparam logic [31:0] NOP          = 32'h0000_0000;
  localparam int          PC_W         = 32;
  localparam int          PC_STEP_DEF  = 4;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int          INSTR_W_DEF  = 32;

endpackage

// File: rtl/fq_storage.sv
// Prefetch entry array: one write port, asynchronous read port.
module fq_storage #(
  parameter int DEPTH = 4,
  parameter int W     = 64,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic [PTR_W-1:0] wr_ptr_i,
  input  logic [W-1:0]     wdata_i,
  input  logic [PTR_W-1:0] rd_ptr_i,
  output logic [W-1:0]     rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[wr_ptr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_i];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: fetch PC, prefetch queue and IF/ID head.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int          ADDR_W   = 8,
  parameter int          DATA_W   = INSTR_W_DEF,
  parameter int          DEPTH    = 4,
  parameter int          PC_STEP  = PC_STEP_DEF,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fetch_en,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic [DATA_W-1:0]        imem_data,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic                     id_valid,
  input  logic                     id_ready,
  output logic [DATA_W-1:0]        id_instr,
  output logic [31:0]              id_pc,
  output logic [31:0]              id_npc,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int EW    = DATA_W + PC_W;

  logic [31:0]      fpc_q, fpc_d;
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             enq, deq;
  logic [EW-1:0]    rdata;

  assign full  = cnt_q == CNT_W'(DEPTH);
  assign empty = cnt_q == '0;
  assign count = cnt_q;

  assign deq = id_valid & id_ready & ~redirect;
  assign enq = fetch_en & ~redirect & (~full | deq);

  assign imem_addr = fpc_q[ADDR_W-1:0];

  assign id_valid = ~empty;
  assign id_pc    = rdata[PC_W-1:0];
  assign id_instr = empty ? DATA_W'(NOP) : rdata[EW-1:PC_W];
  assign id_npc   = id_pc + 32'(PC_STEP);

  fq_storage #(
    .DEPTH (DEPTH),
    .W     (EW),
    .PTR_W (PTR_W)
  ) u_storage (
    .clk      (clk),
    .rst_n    (reset),
    .we_i     (enq),
    .wr_ptr_i (wr_q),
    .wdata_i  ({imem_data, fpc_q}),
    .rd_ptr_i (rd_q),
    .rdata_o  (rdata)
  );

  always_comb begin
    fpc_d = fpc_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (redirect) begin
      fpc_d = redirect_pc;
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (enq) begin
        wr_d  = wr_q + PTR_W'(1);
        fpc_d = fpc_q + 32'(PC_STEP);
      end
      if (deq) begin
        rd_d = rd_q + PTR_W'(1);
      end
      // simultaneous enq and deq leaves occupancy unchanged
      if (enq && !deq) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else if (!enq && deq) begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fpc_q <= RESET_PC;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      fpc_q <= fpc_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: model queue of {instr, pc} entries.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        fetch_en = 1'b0;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_npc;
  logic [2:0]  count;
  logic        full;
  logic        empty;

  int checks = 0;
  int failures = 0;

  logic [63:0] sb[$];
  logic [31:0] mfpc = '0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [7:0] a);
    return 32'hC0DE_0000 | {24'h0, a};
  endfunction

  assign imem_data = rom(imem_addr);

  fetch_queue #(
    .ADDR_W   (8),
    .DATA_W   (32),
    .DEPTH    (DEPTH),
    .PC_STEP  (4),
    .RESET_PC (32'h0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_en    (fetch_en),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .id_npc      (id_npc),
    .count       (count),
    .full        (full),
    .empty       (empty)
  );

  function automatic logic [31:0] exp_instr();
    if (sb.size() == 0) return 32'h0;
    return sb[0][63:32];
  endfunction

  function automatic logic [31:0] exp_pc();
    if (sb.size() == 0) return 32'h0;
    return sb[0][31:0];
  endfunction

  // Drive one cycle of inputs, advance the model in step with the DUT edge.
  task automatic tick(input logic fen, input logic rdy,
                      input logic rd, input logic [31:0] rpc);
    logic menq, mdeq;
    int n;
    fetch_en = fen;
    id_ready = rdy;
    redirect = rd;
    redirect_pc = rpc;
    n = sb.size();
    mdeq = (n != 0) && rdy && !rd;
    menq = fen && !rd && ((n < DEPTH) || mdeq);
    @(posedge clk);
    if (rd) begin
      sb.delete();
      mfpc = rpc;
    end else begin
      if (mdeq) void'(sb.pop_front());
      if (menq) begin
        sb.push_back({rom(mfpc[7:0]), mfpc});
        mfpc = mfpc + 32'd4;
      end
    end
    #1;
    redirect = 1'b0;
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b0;
    fetch_en = 1'b0;
    id_ready = 1'b0;
    redirect = 1'b0;
    sb.delete();
    mfpc = 32'h0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #3;
    checks++;
    if (id_valid !== 1'b0 || count !== 3'd0 || empty !== 1'b1 || full !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags got v=%b c=%0d e=%b f=%b exp v=0 c=0 e=1 f=0",
               id_valid, count, empty, full);
    end
    checks++;
    if (id_instr !== 32'h0 || id_pc !== 32'h0 || imem_addr !== 8'h0) begin
      failures++;
      $display("FAIL reset_vals got instr=%h pc=%h addr=%h exp 0 0 0",
               id_instr, id_pc, imem_addr);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_stream();
    for (int i = 0; i < 10; i++) begin
      tick(1'b1, 1'b1, 1'b0, 32'h0);
      checks++;
      if (id_valid !== 1'b1 || id_pc !== exp_pc() || id_instr !== exp_instr()) begin
        failures++;
        $display("FAIL stream_head[%0d] got v=%b pc=%h i=%h exp v=1 pc=%h i=%h",
                 i, id_valid, id_pc, id_instr, exp_pc(), exp_instr());
      end
      checks++;
      if (id_pc !== 32'(i * 4) || id_npc !== 32'(i * 4 + 4) || count !== 3'd1) begin
        failures++;
        $display("FAIL stream_seq[%0d] got pc=%h npc=%h c=%0d exp pc=%h npc=%h c=1",
                 i, id_pc, id_npc, count, i * 4, i * 4 + 4);
      end
    end
  endtask

  task automatic test_stall_fill();
    do_reset();
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b0, 1'b0, 32'h0);
    checks++;
    if (count !== 3'd4 || full !== 1'b1 || imem_addr !== 8'd16 || id_pc !== 32'h0) begin
      failures++;
      $display("FAIL stall_fill got c=%0d f=%b addr=%0d pc=%h exp c=4 f=1 addr=16 pc=0",
               count, full, imem_addr, id_pc);
    end
    checks++;
    if (id_instr !== rom(8'h0)) begin
      failures++;
      $display("FAIL stall_head got %h exp %h", id_instr, rom(8'h0));
    end
  endtask

  task automatic test_full_enq_deq();
    logic [7:0] addr0;
    for (int i = 0; i < 6; i++) begin
      addr0 = imem_addr;
      checks++;
      if (id_pc !== 32'(i * 4) || id_instr !== rom(8'(i * 4))) begin
        failures++;
        $display("FAIL drain[%0d] got pc=%h i=%h exp pc=%h i=%h",
                 i, id_pc, id_instr, i * 4, rom(8'(i * 4)));
      end
      tick(1'b1, 1'b1, 1'b0, 32'h0);
      checks++;
      if (count !== 3'd4 || imem_addr !== addr0 + 8'd4 || id_pc !== exp_pc()) begin
        failures++;
        $display("FAIL full_enq_deq[%0d] got c=%0d addr=%0d pc=%h exp c=4 addr=%0d pc=%h",
                 i, count, imem_addr, id_pc, addr0 + 8'd4, exp_pc());
      end
    end
  endtask

  task automatic test_fetch_hold();
    logic [7:0] a;
    logic [2:0] c;
    do_reset();
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    a = imem_addr;
    c = count;
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0, 32'h0);
    checks++;
    if (imem_addr !== a || count !== c || imem_addr !== mfpc[7:0]) begin
      failures++;
      $display("FAIL fetch_hold got addr=%0d c=%0d exp addr=%0d c=%0d",
               imem_addr, count, a, c);
    end
    tick(1'b0, 1'b1, 1'b0, 32'h0);
    checks++;
    if (count !== 3'(sb.size()) || id_pc !== exp_pc()) begin
      failures++;
      $display("FAIL hold_deq got c=%0d pc=%h exp c=%0d pc=%h",
               count, id_pc, sb.size(), exp_pc());
    end
  endtask

  task automatic test_redirect(input logic rdy);
    do_reset();
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 32'h0);
    checks++;
    if (count !== 3'd3) begin
      failures++;
      $display("FAIL redir_pre[rdy=%b] got c=%0d exp 3", rdy, count);
    end
    tick(1'b1, rdy, 1'b1, 32'h40);
    checks++;
    if (count !== 3'd0 || id_valid !== 1'b0 || id_instr !== 32'h0 || imem_addr !== 8'h40) begin
      failures++;
      $display("FAIL redir_flush[rdy=%b] got c=%0d v=%b i=%h addr=%h exp 0 0 0 40",
               rdy, count, id_valid, id_instr, imem_addr);
    end
    tick(1'b1, 1'b0, 1'b0, 32'h0);
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h40 || id_instr !== rom(8'h40) ||
        id_pc !== exp_pc() || id_npc !== 32'h44) begin
      failures++;
      $display("FAIL redir_target[rdy=%b] got v=%b pc=%h i=%h npc=%h exp v=1 pc=40 i=%h npc=44",
               rdy, id_valid, id_pc, id_instr, id_npc, rom(8'h40));
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 32'h0);
    #2;
    reset = 1'b0;
    sb.delete();
    mfpc = 32'h0;
    #1;
    checks++;
    if (id_valid !== 1'b0 || count !== 3'd0 || imem_addr !== 8'h0 || id_instr !== 32'h0) begin
      failures++;
      $display("FAIL async_reset got v=%b c=%0d addr=%h i=%h exp 0 0 0 0",
               id_valid, count, imem_addr, id_instr);
    end
    @(negedge clk);
    reset = 1'b1;
    tick(1'b1, 1'b1, 1'b0, 32'h0);
    checks++;
    if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_instr !== exp_instr() || count !== 3'd1) begin
      failures++;
      $display("FAIL after_reset got v=%b pc=%h i=%h c=%0d exp v=1 pc=0 i=%h c=1",
               id_valid, id_pc, id_instr, count, exp_instr());
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall_fill();
    test_full_enq_deq();
    test_fetch_hold();
    test_redirect(1'b1);
    test_redirect(1'b0);
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
